audio_i2s_tx: RTL and testbench

Serial audio output stage that sits directly downstream of the audio mixer. It takes the mixer's signed 16-bit left/right PCM words and serialises them as a standard I2S stream (BCLK, LRCK, SDATA) for the board's external audio DAC. Bit and frame clocks are divided from the system clock, and each frame latches one stereo sample pair. A mute control is applied at frame granularity.

---
 rtl/audio_i2s_tx_pkg.sv | 23 ++
 rtl/audio_i2s_tx_if.sv | 28 ++
 rtl/audio_i2s_tx_clkgen.sv | 48 ++++
 rtl/audio_i2s_tx.sv | 110 +++++++++++
 tb/tb_audio_i2s_tx.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_i2s_tx_pkg.sv
// Shared constants, sample type and gain helper for the I2S transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a; the I2S stream is free-running and never stalls.
package audio_pkg;

    localparam int FRAME_SLOTS = 64;   // BCLK periods per stereo frame
    localparam int WORD_SLOTS  = 32;   // BCLK periods per channel half-frame
    localparam int SAMPLE_W    = 16;
    localparam int GAIN_ONE    = 256;  // unity gain in 1.8 fixed point
    localparam int GAIN_STEP   = 8;    // gain change per frame: 32 frames per full ramp

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // (sample * gain) >>> 8 on a signed product. Gain is always non-negative,
    // so it is zero-extended before the signed multiply. Unity gain (256)
    // passes the sample through unchanged.
    function automatic sample_t apply_gain(sample_t s, logic [8:0] g);
        logic signed [25:0] p;
        p = s * $signed({1'b0, g});
        return p[23:8];
    endfunction

endpackage

// File: rtl/audio_i2s_tx_if.sv
// Mixer-side and DAC-side signals of the I2S transmitter, bundled for port use.
// Latency: n/a (wiring only).
// Backpressure: none; the transmitter pulls one sample pair per frame on sample_strobe.
// Ports: mute, audio_l, audio_r (mixer -> tx); sample_strobe, i2s_bclk,
//        i2s_lrck, i2s_data (tx -> mixer / DAC).
interface audio_i2s_tx_if;
    import audio_pkg::*;

    logic    mute;
    sample_t audio_l;
    sample_t audio_r;
    logic    sample_strobe;
    logic    i2s_bclk;
    logic    i2s_lrck;
    logic    i2s_data;

    // master: the mixer / DAC environment; slave: the transmitter itself
    modport master (
        output mute, audio_l, audio_r,
        input  sample_strobe, i2s_bclk, i2s_lrck, i2s_data
    );

    modport slave (
        input  mute, audio_l, audio_r,
        output sample_strobe, i2s_bclk, i2s_lrck, i2s_data
    );

endinterface

// File: rtl/audio_i2s_tx_clkgen.sv
// Divides clk into BCLK/LRCK and a 64-slot frame counter; emits per-cycle enables.
// Latency: bclk_fall/frame_start are combinational, valid in the cycle before the edge registers.
// Backpressure: none; free-running from reset release.
// Ports: clk, reset_n (sync, active-low); bclk, lrck (registered clocks out);
//        bclk_fall, frame_start (one-cycle enables); next_slot (slot after this fall).
module audio_i2s_clkgen
    import audio_pkg::*;
#(
    parameter int BCLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       bclk,
    output logic       lrck,
    output logic       bclk_fall,
    output logic       frame_start,
    output logic [5:0] next_slot
);

    logic [7:0] div_cnt;
    logic [5:0] slot;
    logic       div_wrap;

    assign div_wrap    = (div_cnt == 8'(BCLK_DIV - 1));
    // bclk is high now and toggles on the wrap, so this edge is a falling one
    assign bclk_fall   = div_wrap && bclk;
    assign next_slot   = slot + 6'd1;
    assign frame_start = bclk_fall && (slot == 6'(FRAME_SLOTS - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
            slot    <= '0;
            lrck    <= 1'b0;
        end else begin
            div_cnt <= div_wrap ? 8'd0 : div_cnt + 8'd1;
            if (div_wrap) begin
                bclk <= ~bclk;
            end
            if (bclk_fall) begin
                slot <= next_slot;
                lrck <= next_slot[5];
            end
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: latches one stereo pair per 64-slot frame, shifts it out MSB first.
// Latency: sample MSB appears on i2s_data one BCLK (2*BCLK_DIV clk) after sample_strobe.
// Backpressure: none; inputs are sampled only at frame start, mid-frame changes are ignored.
// Ports: clk, reset_n (sync, active-low), bus (audio_i2s_tx_if.slave).
// Build option AUDIO_I2S_SOFT_MUTE_EN: mute ramps a 0..256 gain by 8 per frame
// instead of zeroing the sample outright.
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int BCLK_DIV = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    audio_i2s_tx_if.slave  bus
);

    logic       bclk;
    logic       lrck;
    logic       bclk_fall;
    logic       frame_start;
    logic [5:0] next_slot;

    sample_t    sh_l;
    sample_t    sh_r;
    sample_t    load_l;
    sample_t    load_r;
    logic       data_q;
    logic       data_nxt;
    logic       strobe_q;
    logic       in_word;
    logic [3:0] bit_idx;

    audio_i2s_clkgen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_clkgen (
        .clk         (clk),
        .reset_n     (reset_n),
        .bclk        (bclk),
        .lrck        (lrck),
        .bclk_fall   (bclk_fall),
        .frame_start (frame_start),
        .next_slot   (next_slot)
    );

`ifdef AUDIO_I2S_SOFT_MUTE_EN
    logic [8:0] gain;
    logic [8:0] gain_nxt;

    // The gain step is taken first so the new gain applies to this frame's sample.
    always_comb begin
        gain_nxt = gain;
        if (bus.mute) begin
            gain_nxt = (gain < 9'(GAIN_STEP)) ? 9'd0 : gain - 9'(GAIN_STEP);
        end else begin
            gain_nxt = (gain > 9'(GAIN_ONE - GAIN_STEP)) ? 9'(GAIN_ONE) : gain + 9'(GAIN_STEP);
        end
    end

    assign load_l = apply_gain(bus.audio_l, gain_nxt);
    assign load_r = apply_gain(bus.audio_r, gain_nxt);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gain <= '0;
        end else if (frame_start) begin
            gain <= gain_nxt;
        end
    end
`else
    assign load_l = bus.mute ? sample_t'(0) : bus.audio_l;
    assign load_r = bus.mute ? sample_t'(0) : bus.audio_r;
`endif

    // One-bit I2S delay: slot 1 carries bit 15, slot 16 carries bit 0 of each
    // half-frame; slot 0 and slots 17..31 are padding. The mux looks at the
    // slot being entered because data is registered on the same falling edge.
    assign in_word = (next_slot[4:0] != 5'd0) && (next_slot[4:0] <= 5'd16);
    assign bit_idx = 4'(5'd16 - next_slot[4:0]);

    always_comb begin
        data_nxt = 1'b0;
        if (in_word) begin
            data_nxt = next_slot[5] ? sh_r[bit_idx] : sh_l[bit_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sh_l     <= '0;
            sh_r     <= '0;
            data_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= frame_start;
            if (frame_start) begin
                sh_l <= load_l;
                sh_r <= load_r;
            end
            if (bclk_fall) begin
                data_q <= data_nxt;
            end
        end
    end

    assign bus.sample_strobe = strobe_q;
    assign bus.i2s_bclk      = bclk;
    assign bus.i2s_lrck      = lrck;
    assign bus.i2s_data      = data_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx with BCLK_DIV=2: stimulus pushes the expected
// L/R words per frame, a monitor decodes each frame on BCLK rising edges and compares.
// Latency/backpressure: n/a (bench).
module tb_audio_i2s_tx;

    localparam int DIV    = 2;
    localparam int PERIOD = 128 * DIV;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
    } exp_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   fails;
    exp_t expq[$];

    audio_i2s_tx_if bus ();

    audio_i2s_tx #(
        .BCLK_DIV (DIV)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        exp_t e;
        e.l = l;
        e.r = r;
        expq.push_back(e);
    endtask

    // Wait for the next sample_strobe (bounded) and queue what that frame must carry.
    task automatic next_frame(input logic [15:0] l, input logic [15:0] r);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.sample_strobe && n < 2 * PERIOD);
        check("strobe_seen", bus.sample_strobe, 1);
        push(l, r);
    endtask

    // Cycles to first strobe after reset release; push its expectation.
    task automatic measure_to_strobe(input string name, input logic [15:0] l, input logic [15:0] r);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.sample_strobe && k < 2 * PERIOD);
        check(name, k, PERIOD);
        push(l, r);
    endtask

    task automatic wait_slots(input int n);
        repeat (n * 2 * DIV) @(negedge clk);
    endtask

`ifdef AUDIO_I2S_SOFT_MUTE_EN
    function automatic logic [15:0] scaled(input logic [15:0] s, input int g);
        int v;
        v = $signed(s);
        v = (v * g) >>> 8;
        return v[15:0];
    endfunction
`endif

    // Monitor: samples 2 time units after each rising clk edge.
    int          mk;
    int          since;
    bit          in_frame;
    bit          have_prev;
    bit          prev_bclk;
    bit          lrck_bad;
    logic [63:0] fb;

    initial begin
        in_frame  = 0;
        have_prev = 0;
        prev_bclk = 0;
        since     = 0;
        mk        = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!reset_n) begin
                if (in_frame && expq.size() > 0) expq.delete(0);
                in_frame  = 0;
                have_prev = 0;
                prev_bclk = 0;
                since     = 0;
            end else begin
                since++;
                if (bus.sample_strobe) begin
                    check("strobe_align", in_frame, 0);
                    if (have_prev) check("strobe_period", since, PERIOD);
                    have_prev = 1;
                    since     = 0;
                    in_frame  = 1;
                    mk        = 0;
                    lrck_bad  = 0;
                    fb        = '0;
                end
                if (in_frame && !prev_bclk && bus.i2s_bclk) begin
                    fb[mk] = bus.i2s_data;
                    if (bus.i2s_lrck !== (mk >= 32)) lrck_bad = 1;
                    mk++;
                    if (mk == 64) begin
                        logic [15:0] gl, gr;
                        logic [63:0] pad;
                        for (int i = 0; i < 16; i++) begin
                            gl[15-i] = fb[1+i];
                            gr[15-i] = fb[33+i];
                        end
                        pad = fb;
                        for (int i = 0; i < 16; i++) begin
                            pad[1+i]  = 1'b0;
                            pad[33+i] = 1'b0;
                        end
                        in_frame = 0;
                        if (expq.size() == 0) begin
                            check("frame_expected", 0, 1);
                        end else begin
                            check("word_l", gl, expq[0].l);
                            check("word_r", gr, expq[0].r);
                            check("pad_bits_zero", pad[31:0] | pad[63:32], 0);
                            check("lrck_slots", lrck_bad, 0);
                            expq.delete(0);
                        end
                    end
                end
                prev_bclk = bus.i2s_bclk;
            end
        end
    end

    // Stimulus
    initial begin
        int k, rise_at, fall_at;
        checks  = 0;
        fails   = 0;
        reset_n = 1'b0;
        bus.mute = 1'b0;
`ifdef AUDIO_I2S_SOFT_MUTE_EN
        bus.audio_l = 16'h4000;
        bus.audio_r = 16'hC000;
`else
        bus.audio_l = 16'hA5C3;
        bus.audio_r = 16'h7FFF;
`endif
        repeat (10) @(negedge clk);
        check("rst_bclk", bus.i2s_bclk, 0);
        check("rst_lrck", bus.i2s_lrck, 0);
        check("rst_data", bus.i2s_data, 0);
        check("rst_strobe", bus.sample_strobe, 0);
        reset_n = 1'b1;

        // Edge timing after release: sample k is taken after the k-th rising clk edge.
        k = 0;
        rise_at = -1;
        fall_at = -1;
        do begin
            @(negedge clk);
            k++;
            if (bus.i2s_bclk && rise_at < 0) rise_at = k;
            if (!bus.i2s_bclk && rise_at >= 0 && fall_at < 0) fall_at = k;
        end while (!bus.sample_strobe && k < 2 * PERIOD);
        check("first_bclk_rise", rise_at, DIV);
        check("first_bclk_fall", fall_at, 2 * DIV);
        check("first_strobe", k, PERIOD);

`ifdef AUDIO_I2S_SOFT_MUTE_EN
        // Fade in: frame f has gain 8*f.
        push(16'h0200, 16'hFE00);
        for (int f = 2; f <= 32; f++) begin
            next_frame(scaled(16'h4000, 8 * f), scaled(16'hC000, 8 * f));
        end
        bus.mute = 1'b1;
        next_frame(16'h3E00, 16'hC200);
        for (int j = 2; j <= 32; j++) begin
            next_frame(scaled(16'h4000, 256 - 8 * j), scaled(16'hC000, 256 - 8 * j));
        end
        bus.mute    = 1'b0;
        bus.audio_l = 16'hFFFF;
        next_frame(16'hFFFF, 16'hFE00);
        bus.audio_l = 16'h4000;
        next_frame(16'h0400, 16'hFC00);
`else
        push(16'hA5C3, 16'h7FFF);
        // Input change mid-frame lands in the next frame only.
        wait_slots(10);
        bus.audio_l = 16'h0001;
        next_frame(16'h0001, 16'h7FFF);
        // Mute raised mid-frame: current frame intact, next frame silent.
        wait_slots(5);
        bus.audio_l = 16'h8000;
        wait_slots(15);
        bus.mute = 1'b1;
        next_frame(16'h0000, 16'h0000);
        wait_slots(8);
        bus.mute = 1'b0;
        next_frame(16'h8000, 16'h7FFF);
`endif

        // One-cycle reset at slot 40 aborts the frame in flight.
        wait_slots(40);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_bclk", bus.i2s_bclk, 0);
        check("midrst_lrck", bus.i2s_lrck, 0);
        check("midrst_data", bus.i2s_data, 0);
        reset_n = 1'b1;
`ifdef AUDIO_I2S_SOFT_MUTE_EN
        measure_to_strobe("strobe_after_midrst", 16'h0200, 16'hFE00);
`else
        measure_to_strobe("strobe_after_midrst", 16'h8000, 16'h7FFF);
`endif

        k = 0;
        while (expq.size() != 0 && k < 2 * PERIOD) begin
            @(negedge clk);
            k++;
        end
        check("scoreboard_drained", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
